// File: rtl/bsg_downstream_rx_fifo_if.sv
// Handshake bundle for the downstream receiver: IO flit side, core word side and status.
// Signal widths are derived from the same parameters the receiver uses.
interface bsg_downstream_rx_fifo_if #(
   parameter int IO_W  = 8,
   parameter int RATIO = 4,
   parameter int DEPTH = 64
);
   localparam int AW     = $clog2(DEPTH);
   localparam int CORE_W = IO_W * RATIO;

   logic              io_valid_in;
   logic [IO_W-1:0]   io_data_in;
   logic              io_token_out;
   logic              core_valid_out;
   logic [CORE_W-1:0] core_data_out;
   logic              core_ready;
   logic [AW:0]       occupancy;
   logic              overflow_err;

   modport slave (
      input  io_valid_in, io_data_in, core_ready,
      output io_token_out, core_valid_out, core_data_out, occupancy, overflow_err
   );

   modport master (
      output io_valid_in, io_data_in, core_ready,
      input  io_token_out, core_valid_out, core_data_out, occupancy, overflow_err
   );
endinterface

// File: rtl/bsg_downstream_rx_fifo.sv
// Downstream receiver: circular flit buffer, RATIO-flit little-endian word assembly,
// batched credit return, sticky overflow flag and occupancy reporting.
module bsg_downstream_rx_fifo #(
   parameter int IO_W        = 8,
   parameter int RATIO       = 4,
   parameter int DEPTH       = 64,
   parameter int TOKEN_BATCH = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   bsg_downstream_rx_fifo_if.slave bus
);
   localparam int AW     = $clog2(DEPTH);
   localparam int CORE_W = IO_W * RATIO;
   localparam int SW     = $clog2(RATIO);
   localparam int TW     = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;
   localparam logic [SW-1:0] SUB_LAST   = SW'(RATIO - 1);
   localparam logic [TW-1:0] FREED_LAST = TW'(TOKEN_BATCH - 1);

   logic [IO_W-1:0]             mem [DEPTH];
   logic [AW:0]                 wptr, rptr, occ;
   logic [SW-1:0]               sub;
   logic [TW-1:0]               freed;
   logic [RATIO-2:0][IO_W-1:0]  shadow;
   logic [CORE_W-1:0]           core_data;
   logic                        core_valid, token, overflow;
   logic                        full, empty, wr_en, rd_en, rd_last;
   logic [IO_W-1:0]             rd_data;

   // Occupancy never exceeds DEPTH, so its MSB alone marks full.
   assign occ     = wptr - rptr;
   assign full    = occ[AW];
   assign empty   = (occ == '0);
   assign wr_en   = bus.io_valid_in && !full;
   assign rd_last = (sub == SUB_LAST);
   assign rd_en   = !empty && (!rd_last || !core_valid || bus.core_ready);
   assign rd_data = mem[rptr[AW-1:0]];

   assign bus.occupancy      = occ;
   assign bus.overflow_err   = overflow;
   assign bus.io_token_out   = token;
   assign bus.core_valid_out = core_valid;
   assign bus.core_data_out  = core_data;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= bus.io_data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr       <= '0;
         rptr       <= '0;
         sub        <= '0;
         freed      <= '0;
         shadow     <= '0;
         core_data  <= '0;
         core_valid <= 1'b0;
         token      <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         token <= 1'b0;
         if (wr_en) wptr <= wptr + 1'b1;
         if (bus.io_valid_in && full) overflow <= 1'b1;
         // A final-flit read in the same cycle overrides the accept-driven clear.
         if (core_valid && bus.core_ready) core_valid <= 1'b0;
         if (rd_en) begin
            rptr <= rptr + 1'b1;
            if (freed == FREED_LAST) begin
               freed <= '0;
               token <= 1'b1;
            end else begin
               freed <= freed + 1'b1;
            end
            if (rd_last) begin
               core_data  <= {rd_data, shadow};
               core_valid <= 1'b1;
               sub        <= '0;
            end else begin
               shadow[sub] <= rd_data;
               sub         <= sub + 1'b1;
            end
         end
      end
   end
endmodule
